instruction_fetch_stage: RTL and testbench

- Fetch stage of the 5-stage pipelined processor.
- Owns the program counter and drives the word-indexed instruction memory's byte `address` input.
- Captures the returned `instruction` into the IF/ID pipeline register.
- Handles stall from the hazard unit, flush, and branch/jump redirects from later stages, plus an out-of-range-PC halt.

---
 rtl/instruction_fetch_stage.sv | 105 ++++++++++
 tb/tb_instruction_fetch_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction memory, and loads the IF/ID register.
// Handles stall, flush, branch/jump redirects, and halts on out-of-range PCs.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fault
);

    localparam logic [31:0] PC_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] target_raw, target;
    logic        redirect;
    logic        bubble;
    logic [31:0] instr_next, pc4_next;
    logic        valid_next;
    logic        fault_next;

    assign address    = pc;
    assign pc_plus4   = pc + 32'd4;
    assign redirect   = branch_taken | jump;
    // The branch is the older instruction, so it wins over a same-cycle jump.
    assign target_raw = branch_taken ? branch_target : jump_target;
    assign target     = target_raw & ~32'd3;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = if_id_instruction;
        pc4_next   = if_id_pc_plus4;
        valid_next = if_id_valid;
        bubble     = 1'b0;

        if (redirect) begin
            pc_next = target;
            bubble  = 1'b1;
            if (state == HALTED && target < PC_LIMIT) begin
                state_next = RUN;
            end
        end else if (stall) begin
            bubble = flush;
        end else if (state == HALTED) begin
            bubble = 1'b1;
        end else if (pc >= PC_LIMIT) begin
            // PC holds at the faulting address so it can be inspected.
            state_next = HALTED;
            bubble     = 1'b1;
        end else if (flush) begin
            bubble  = 1'b1;
            pc_next = pc_plus4;
        end else begin
            instr_next = instruction;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
            pc_next    = pc_plus4;
        end

        if (bubble) begin
            instr_next = 32'd0;
            pc4_next   = 32'd0;
            valid_next = 1'b0;
        end

        fault_next = (state_next == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= RUN;
            pc                <= RESET_PC;
            if_id_instruction <= 32'd0;
            if_id_pc_plus4    <= 32'd0;
            if_id_valid       <= 1'b0;
            fault             <= 1'b0;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            if_id_instruction <= instr_next;
            if_id_pc_plus4    <= pc4_next;
            if_id_valid       <= valid_next;
            fault             <= fault_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: per-scenario step tables with an IF/ID scoreboard.
`timescale 1ns/1ps
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        stall = 1'b0, flush = 1'b0;
    logic        branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = 32'd0, jump_target = 32'd0;
    logic [31:0] if_id_instruction, if_id_pc_plus4;
    logic        if_id_valid, fault;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jmpt;
        logic [31:0] eaddr;
        logic        efault;
        ifid_t       eifid;
    } step_t;

    localparam ifid_t BUBBLE = '0;

    ifid_t sb[$];
    int    compared = 0;
    int    mismatched = 0;

    instruction_fetch_stage #(.RESET_PC(32'd0), .MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .address(address), .instruction(instruction),
        .stall(stall), .flush(flush), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .fault(fault)
    );

    always #1000 clk = ~clk;

    // Combinational instruction memory: word i holds C0DE0000+i, out of range reads DEADBEEF.
    assign instruction = (address < 32'h1000) ? (32'hC0DE_0000 + {2'b00, address[31:2]})
                                              : 32'hDEAD_BEEF;

    function automatic ifid_t fetched(int word);
        fetched.instr = 32'hC0DE_0000 + 32'(word);
        fetched.pc4   = 32'(4 * word + 4);
        fetched.valid = 1'b1;
    endfunction

    function automatic step_t mk(logic s, logic f, logic b, logic [31:0] bt, logic j,
                                 logic [31:0] jt, logic [31:0] ea, logic ef, ifid_t ei);
        mk.stall = s;  mk.flush = f;  mk.br = b;  mk.brt = bt;
        mk.jmp = j;    mk.jmpt = jt;  mk.eaddr = ea;  mk.efault = ef;  mk.eifid = ei;
    endfunction

    function automatic step_t nrm(logic [31:0] ea, logic ef, ifid_t ei);
        return mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, ea, ef, ei);
    endfunction

    task automatic applyStimulus(step_t s);
        stall         = s.stall;
        flush         = s.flush;
        branch_taken  = s.br;
        branch_target = s.brt;
        jump          = s.jmp;
        jump_target   = s.jmpt;
        sb.push_back(s.eifid);
    endtask

    task automatic do_reset();
        applyStimulus(nrm(32'd0, 1'b0, BUBBLE));
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        #10;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        compared++;
        if ({address, if_id_instruction, if_id_pc_plus4, if_id_valid, fault} !== 98'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: addr=%h ifid=%h/%h/%b fault=%b, want all zero",
                     address, if_id_instruction, if_id_pc_plus4, if_id_valid, fault);
        end
        @(posedge clk);
        #1;
        compared++;
        if (address !== 32'd0 || if_id_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_held: addr=%h valid=%b, want 0/0", address, if_id_valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_table(string name, step_t steps[$]);
        ifid_t act, exp;
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            @(posedge clk);
            #1;
            act = {if_id_instruction, if_id_pc_plus4, if_id_valid};
            exp = sb.pop_front();
            compared++;
            if (act !== exp) begin
                mismatched++;
                $display("[TB] FAIL %s step %0d ifid: got %h/%h/%b want %h/%h/%b", name, i,
                         act.instr, act.pc4, act.valid, exp.instr, exp.pc4, exp.valid);
            end
            compared++;
            if (address !== steps[i].eaddr || fault !== steps[i].efault) begin
                mismatched++;
                $display("[TB] FAIL %s step %0d pc: got addr=%h fault=%b want addr=%h fault=%b",
                         name, i, address, fault, steps[i].eaddr, steps[i].efault);
            end
        end
        applyStimulus(nrm(32'd0, 1'b0, BUBBLE));
        void'(sb.pop_back());
    endtask

    task automatic test_sequential();
        step_t t[$];
        for (int i = 0; i < 4; i++) t.push_back(nrm(32'(4 * i + 4), 1'b0, fetched(i)));
        run_table("sequential", t);
    endtask

    task automatic test_stall();
        step_t t[$];
        do_reset();
        t.push_back(nrm(32'd4, 1'b0, fetched(0)));
        t.push_back(nrm(32'd8, 1'b0, fetched(1)));
        t.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd8, 1'b0, fetched(1)));
        t.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd8, 1'b0, fetched(1)));
        t.push_back(nrm(32'd12, 1'b0, fetched(2)));
        t.push_back(nrm(32'd16, 1'b0, fetched(3)));
        run_table("stall", t);
    endtask

    task automatic test_branch_vs_jump();
        step_t t[$];
        do_reset();
        for (int i = 0; i < 3; i++) t.push_back(nrm(32'(4 * i + 4), 1'b0, fetched(i)));
        t.push_back(mk(1'b0, 1'b0, 1'b1, 32'h43, 1'b1, 32'h80, 32'h40, 1'b0, BUBBLE));
        t.push_back(nrm(32'h44, 1'b0, fetched(16)));
        run_table("branch_vs_jump", t);
    endtask

    task automatic test_flush();
        step_t t[$];
        t.push_back(mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h48, 1'b0, BUBBLE));
        t.push_back(nrm(32'h4C, 1'b0, fetched(18)));
        t.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h4C, 1'b0, BUBBLE));
        t.push_back(nrm(32'h50, 1'b0, fetched(19)));
        run_table("flush", t);
    endtask

    task automatic test_redirect_stall_flush();
        step_t t[$];
        t.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h20, 32'h20, 1'b0, BUBBLE));
        t.push_back(nrm(32'h24, 1'b0, fetched(8)));
        run_table("redirect_stall_flush", t);
    endtask

    task automatic test_out_of_range();
        step_t t[$];
        t.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFF, 32'hFFC, 1'b0, BUBBLE));
        t.push_back(nrm(32'h1000, 1'b0, fetched(1023)));
        t.push_back(nrm(32'h1000, 1'b1, BUBBLE));
        t.push_back(nrm(32'h1000, 1'b1, BUBBLE));
        t.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h1000, 1'b1, BUBBLE));
        t.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h2003, 32'h2000, 1'b1, BUBBLE));
        t.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h2000, 32'h0, 1'b0, BUBBLE));
        t.push_back(nrm(32'h4, 1'b0, fetched(0)));
        run_table("out_of_range", t);
    endtask

    task automatic test_async_reset();
        step_t t[$];
        t.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3C, 32'h3C, 1'b0, BUBBLE));
        t.push_back(nrm(32'h40, 1'b0, fetched(15)));
        run_table("async_reset_prep", t);
        #500;
        reset = 1'b1;
        #1;
        compared++;
        if (address !== 32'd0 || if_id_valid !== 1'b0 || fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_run: addr=%h valid=%b fault=%b want 0/0/0",
                     address, if_id_valid, fault);
        end
        @(negedge clk);
        reset = 1'b0;
        t.delete();
        t.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1000, 32'h1000, 1'b0, BUBBLE));
        t.push_back(nrm(32'h1000, 1'b1, BUBBLE));
        run_table("async_reset_halt_prep", t);
        #500;
        reset = 1'b1;
        #1;
        compared++;
        if (address !== 32'd0 || fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_halt: addr=%h fault=%b want 0/0", address, fault);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_vs_jump();
        test_flush();
        test_redirect_stall_flush();
        test_out_of_range();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
